// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port arbiter and sequencer for the 16384 x 16-bit block
// memory. Shares the memory between instruction fetch (read-only) and the data
// port (read/write). The data port has priority, and a starvation guard
// protects fetch. Read data returns with the memory's one-cycle latency. After
// reset the memory can be zero-filled before any requester is granted.
//
// Ports:
//   clka, rsta          clock, synchronous active-high reset
//   if_req/if_addr      fetch read request and word address
//   if_gnt              fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata  fetch read return (data mirrors mem_douta)
//   dm_req/dm_we/dm_addr/dm_wdata  data request, write flag, address, write value
//   dm_gnt              data accepted this cycle (combinational)
//   dm_rvalid/dm_rdata  data read return (data mirrors mem_douta)
//   busy                high during reset and the clear sweep
//   mem_*               block-memory port A drive and read data
module mem_arbiter #(
  parameter bit          CLEAR_EN     = 1'b1,
  parameter int unsigned CLEAR_DEPTH  = 16384,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clka,
  input  logic        rsta,
  input  logic        if_req,
  input  logic [13:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [15:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [13:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [15:0] dm_rdata,
  output logic        busy,
  output logic        mem_rsta,
  output logic [0:0]  mem_wea,
  output logic [13:0] mem_addra,
  output logic [15:0] mem_dina,
  input  logic [15:0] mem_douta
);

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 16;
  // One bit wider than the address so a full 16384-word sweep can terminate.
  localparam int unsigned CW = 15;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_clr_cnt;
  logic [CW-1:0]   w_clr_cnt_nxt;
  logic [SW-1:0]   r_starve_cnt;
  logic [SW-1:0]   w_starve_nxt;
  logic            r_if_rvalid;
  logic            r_dm_rvalid;
  logic            w_starved;

  assign w_starved = (r_starve_cnt >= SW'(STARVE_LIMIT));

  // State, sweep counter, starvation counter and read-return flags.
  always_ff @(posedge clka) begin
    if (rsta) begin
      r_state      <= CLEAR_EN ? ST_CLEAR : ST_RUN;
      r_clr_cnt    <= '0;
      r_starve_cnt <= '0;
      r_if_rvalid  <= 1'b0;
      r_dm_rvalid  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_clr_cnt    <= w_clr_cnt_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_if_rvalid  <= if_gnt;
      r_dm_rvalid  <= dm_gnt & ~dm_we;
    end
  end

  // Next state, grants and memory drive.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_starve_nxt  = '0;
    if_gnt        = 1'b0;
    dm_gnt        = 1'b0;
    busy          = 1'b0;
    mem_wea       = 1'b0;
    mem_addra     = '0;
    mem_dina      = '0;

    if (rsta) begin
      busy = 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          busy          = 1'b1;
          mem_wea       = 1'b1;
          mem_addra     = r_clr_cnt[AW-1:0];
          mem_dina      = DW'(0);
          w_clr_cnt_nxt = r_clr_cnt + CW'(1);
          if (r_clr_cnt == CW'(CLEAR_DEPTH - 1)) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          // Fetch only overrides a competing data request once starved.
          if (if_req && (!dm_req || w_starved)) begin
            if_gnt    = 1'b1;
            mem_addra = if_addr;
          end else if (dm_req) begin
            dm_gnt    = 1'b1;
            mem_wea   = dm_we;
            mem_addra = dm_addr;
            mem_dina  = dm_wdata;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase

      // Count consecutive fetch denials, saturating at the limit.
      if (if_req && !if_gnt) begin
        w_starve_nxt = w_starved ? r_starve_cnt : r_starve_cnt + SW'(1);
      end
    end
  end

  // A read granted just before reset must not report valid during reset.
  assign if_rvalid = r_if_rvalid & ~rsta;
  assign dm_rvalid = r_dm_rvalid & ~rsta;
  assign if_rdata  = mem_douta;
  assign dm_rdata  = mem_douta;
  assign mem_rsta  = rsta;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int DEPTH = 8;
  localparam int LIMIT = 4;
  localparam bit CLR_EN = 1'b1;

  logic        clk;
  logic        rsta;
  logic        if_req;
  logic [13:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [15:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [13:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [15:0] dm_rdata;
  logic        busy;
  logic        mem_rsta;
  logic [0:0]  mem_wea;
  logic [13:0] mem_addra;
  logic [15:0] mem_dina;
  logic [15:0] mem_douta;

  int checks;
  int errors;

  mem_arbiter #(
    .CLEAR_EN     (CLR_EN),
    .CLEAR_DEPTH  (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clka      (clk),
    .rsta      (rsta),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .busy      (busy),
    .mem_rsta  (mem_rsta),
    .mem_wea   (mem_wea),
    .mem_addra (mem_addra),
    .mem_dina  (mem_dina),
    .mem_douta (mem_douta)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1);
  end

  // Block memory: read-first, one-cycle latency, output zeroed under reset.
  logic [15:0] mem_arr [0:16383];
  logic        tb_preload;
  always @(posedge clk) begin
    if (tb_preload) begin
      for (int i = 0; i < 16384; i++) mem_arr[i] <= 16'hFFFF;
    end
    if (mem_rsta) begin
      mem_douta <= 16'h0000;
    end else begin
      if (mem_wea[0]) mem_arr[mem_addra] <= mem_dina;
      mem_douta <= mem_arr[mem_addra];
    end
  end

  // Reference model state: what the memory should hold and what is owed back.
  bit          m_clearing;
  int          m_clr_idx;
  int          m_starve;
  bit          m_pend_if;
  bit          m_pend_dm;
  logic [15:0] m_if_data;
  logic [15:0] m_dm_data;
  logic [15:0] exp_mem [0:16383];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare all outputs for the current cycle, then advance the model one edge.
  task automatic model_step();
    logic        e_if, e_dm, e_wea, e_busy, chk_din, f_win, d_win;
    logic [13:0] e_addr;
    logic [15:0] e_din;
    e_if = 1'b0; e_dm = 1'b0; e_wea = 1'b0; e_busy = 1'b0;
    chk_din = 1'b1; f_win = 1'b0; d_win = 1'b0;
    e_addr = 14'h0; e_din = 16'h0;
    if (rsta) begin
      e_busy = 1'b1;
    end else if (m_clearing) begin
      e_busy = 1'b1;
      e_wea  = 1'b1;
      e_addr = 14'(m_clr_idx);
    end else begin
      f_win = if_req && (!dm_req || m_starve >= LIMIT);
      d_win = !f_win && dm_req;
      if (f_win) begin
        e_if = 1'b1; e_addr = if_addr; chk_din = 1'b0;
      end else if (d_win) begin
        e_dm = 1'b1; e_wea = dm_we; e_addr = dm_addr; e_din = dm_wdata;
      end
    end

    chk("if_gnt", if_gnt, e_if);
    chk("dm_gnt", dm_gnt, e_dm);
    chk("busy", busy, e_busy);
    chk("mem_rsta", mem_rsta, rsta);
    chk("mem_wea", mem_wea, e_wea);
    chk("mem_addra", mem_addra, e_addr);
    if (chk_din) chk("mem_dina", mem_dina, e_din);
    chk("if_rvalid", if_rvalid, !rsta && m_pend_if);
    chk("dm_rvalid", dm_rvalid, !rsta && m_pend_dm);
    if (!rsta && m_pend_if) chk("if_rdata", if_rdata, m_if_data);
    if (!rsta && m_pend_dm) chk("dm_rdata", dm_rdata, m_dm_data);

    if (rsta) begin
      m_clearing = CLR_EN;
      m_clr_idx  = 0;
      m_starve   = 0;
      m_pend_if  = 1'b0;
      m_pend_dm  = 1'b0;
    end else begin
      if (m_clearing) begin
        exp_mem[m_clr_idx] = 16'h0000;
        m_clr_idx++;
        if (m_clr_idx >= DEPTH) m_clearing = 1'b0;
      end
      m_pend_if = f_win;
      m_if_data = exp_mem[if_addr];
      m_pend_dm = d_win && !dm_we;
      m_dm_data = exp_mem[dm_addr];
      if (d_win && dm_we) exp_mem[dm_addr] = dm_wdata;
      if (if_req && !f_win) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
      else m_starve = 0;
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_step();
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    at_neg();
    next_cycle();
  endtask

  task automatic fetch(input logic [13:0] a, input logic [15:0] exp);
    if_req = 1'b1; if_addr = a;
    at_neg();
    chk("fetch_gnt", if_gnt, 1'b1);
    next_cycle();
    if_req = 1'b0;
    at_neg();
    chk("fetch_rvalid", if_rvalid, 1'b1);
    chk("fetch_rdata", if_rdata, exp);
    next_cycle();
  endtask

  task automatic dm_write(input logic [13:0] a, input logic [15:0] d);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = a; dm_wdata = d;
    at_neg();
    chk("wr_gnt", dm_gnt, 1'b1);
    next_cycle();
    dm_req = 1'b0; dm_we = 1'b0;
    at_neg();
    chk("wr_no_rvalid", dm_rvalid, 1'b0);
    next_cycle();
  endtask

  task automatic dm_read(input logic [13:0] a, input logic [15:0] exp);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = a;
    at_neg();
    chk("rd_gnt", dm_gnt, 1'b1);
    next_cycle();
    dm_req = 1'b0;
    at_neg();
    chk("rd_rvalid", dm_rvalid, 1'b1);
    chk("rd_rdata", dm_rdata, exp);
    next_cycle();
  endtask

  initial begin
    bit [5:0] pat;
    bit       fell;
    checks = 0; errors = 0;
    for (int i = 0; i < 16384; i++) exp_mem[i] = 16'hFFFF;
    m_clearing = 1'b0; m_clr_idx = 0; m_starve = 0;
    m_pend_if = 1'b0; m_pend_dm = 1'b0; m_if_data = 16'h0; m_dm_data = 16'h0;
    rsta = 1'b1; tb_preload = 1'b1;
    if_req = 1'b0; if_addr = 14'h0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 14'h0; dm_wdata = 16'h0;
    next_cycle();
    tb_preload = 1'b0;

    // Reset state.
    at_neg();
    chk("rst_busy", busy, 1'b1);
    chk("rst_wea", mem_wea, 1'b0);
    next_cycle();
    cyc();

    // Clear sweep over addresses 0..7.
    rsta = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      at_neg();
      chk("clr_addr", mem_addra, 14'(k));
      chk("clr_wea", mem_wea, 1'b1);
      chk("clr_busy", busy, 1'b1);
      next_cycle();
    end
    at_neg();
    chk("clr_done_busy", busy, 1'b0);
    next_cycle();
    fetch(14'd5, 16'h0000);

    // Write then read.
    dm_write(14'd2, 16'd420);
    dm_read(14'd2, 16'd420);
    dm_write(14'd4, 16'd69);
    dm_read(14'd4, 16'd69);

    // Read granted the cycle right after a write to the same address.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 14'd7; dm_wdata = 16'h1234;
    at_neg();
    chk("b2b_wr_gnt", dm_gnt, 1'b1);
    next_cycle();
    dm_we = 1'b0;
    at_neg();
    chk("b2b_rd_gnt", dm_gnt, 1'b1);
    chk("b2b_no_rvalid", dm_rvalid, 1'b0);
    next_cycle();
    dm_req = 1'b0;
    at_neg();
    chk("b2b_rvalid", dm_rvalid, 1'b1);
    chk("b2b_rdata", dm_rdata, 16'h1234);
    next_cycle();

    // Simultaneous requests: data first, fetch next cycle.
    if_req = 1'b1; if_addr = 14'd4;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 14'd2;
    at_neg();
    chk("sim_dm_gnt", dm_gnt, 1'b1);
    chk("sim_if_wait", if_gnt, 1'b0);
    next_cycle();
    dm_req = 1'b0;
    at_neg();
    chk("sim_if_gnt", if_gnt, 1'b1);
    chk("sim_dm_rdata", dm_rdata, 16'd420);
    next_cycle();
    if_req = 1'b0;
    at_neg();
    chk("sim_if_rvalid", if_rvalid, 1'b1);
    chk("sim_if_rdata", if_rdata, 16'd69);
    next_cycle();

    // Starvation guard: four data grants, one fetch, then data again.
    pat = 6'b010000;
    if_req = 1'b1; if_addr = 14'd4;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 14'd2;
    for (int k = 0; k < 6; k++) begin
      at_neg();
      chk("starve_if_gnt", if_gnt, pat[k]);
      chk("starve_dm_gnt", dm_gnt, !pat[k]);
      next_cycle();
    end
    if_req = 1'b0; dm_req = 1'b0;
    cyc();

    // Reset during an outstanding read, then reset mid-sweep.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 14'd2;
    at_neg();
    chk("rr_gnt", dm_gnt, 1'b1);
    next_cycle();
    dm_req = 1'b0; rsta = 1'b1;
    at_neg();
    chk("rr_rvalid_dropped", dm_rvalid, 1'b0);
    chk("rr_wea", mem_wea, 1'b0);
    chk("rr_busy", busy, 1'b1);
    next_cycle();
    cyc();
    rsta = 1'b0;
    at_neg();
    chk("rr_restart_addr", mem_addra, 14'd0);
    chk("rr_restart_wea", mem_wea, 1'b1);
    next_cycle();
    cyc();
    cyc();
    rsta = 1'b1;
    cyc();
    rsta = 1'b0;
    at_neg();
    chk("midclr_restart_addr", mem_addra, 14'd0);
    next_cycle();
    fell = 1'b0;
    for (int k = 0; k < 40; k++) begin
      at_neg();
      if (!busy) begin
        fell = 1'b1;
        next_cycle();
        break;
      end
      next_cycle();
    end
    chk("busy_fall_in_time", fell, 1'b1);

    // Cleared words read zero; words past the sweep keep the preload.
    fetch(14'd2, 16'h0000);
    fetch(14'd8, 16'hFFFF);
    fetch(14'd100, 16'hFFFF);
    dm_read(14'd7, 16'h0000);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
